// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: validates the hps_io ioctl ROM download stream, forwards
// accepted bytes to the core's dn_* port and owns the core's active-low reset.
// Optional feature macro: ROM_CHECKSUM_EN (adds a mod-256 byte-sum check).
module rom_load_sequencer #(
  parameter logic [16:0] EXPECTED_LEN = 17'd6656,
  parameter int unsigned RESET_HOLD   = 16,
  parameter logic [7:0]  EXPECTED_SUM = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        user_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset_n,
  output logic        rom_ready,
  output logic        load_error
);

  localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    S_EMPTY, S_LOAD, S_CHECK, S_HOLD, S_RUN, S_ERROR
  } state_t;

  state_t            state, state_n;
  logic              dl_q;
  logic              dl_rise;
  logic [16:0]       byte_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              bad;
  logic              wr_in_load;
  logic              accept;
  logic              load_ok;

  assign dl_rise    = ioctl_download & ~dl_q;
  assign wr_in_load = (state == S_LOAD) && ioctl_wr;
  assign accept     = wr_in_load && (ioctl_addr == {8'd0, byte_cnt}) &&
                      (byte_cnt < EXPECTED_LEN);

`ifdef ROM_CHECKSUM_EN
  logic [7:0] sum;
  assign load_ok = !bad && (byte_cnt == EXPECTED_LEN) && (sum == EXPECTED_SUM);

  // Running mod-256 sum of accepted bytes, cleared when a new download starts.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)        sum <= '0;
    else if (dl_rise) sum <= '0;
    else if (accept)  sum <= sum + ioctl_data;
  end
`else
  assign load_ok = !bad && (byte_cnt == EXPECTED_LEN);
`endif

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_n;
  end

  // Next-state logic; a download rising edge overrides every other transition.
  always_comb begin
    state_n = state;
    case (state)
      S_LOAD:  if (!ioctl_download) state_n = S_CHECK;
      S_CHECK: state_n = load_ok ? S_HOLD : S_ERROR;
      S_HOLD:  if (!user_reset && (hold_cnt == HOLD_LAST)) state_n = S_RUN;
      S_RUN:   if (user_reset) state_n = S_HOLD;
      default: state_n = state;
    endcase
    if (dl_rise) state_n = S_LOAD;
  end

  // Download datapath: edge detect, byte acceptance, hold timer.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_q     <= 1'b0;
      dn_addr  <= '0;
      dn_data  <= '0;
      dn_wr    <= 1'b0;
      byte_cnt <= '0;
      bad      <= 1'b0;
      hold_cnt <= '0;
    end else begin
      dl_q     <= ioctl_download;
      dn_wr    <= 1'b0;
      // Cleared outside HOLD, so HOLD always starts at 0; user_reset restarts it.
      hold_cnt <= (state == S_HOLD && !user_reset) ? hold_cnt + 1'b1 : '0;
      if (dl_rise) begin
        byte_cnt <= '0;
        bad      <= 1'b0;
      end else if (accept) begin
        dn_addr  <= ioctl_addr[16:0];
        dn_data  <= ioctl_data;
        dn_wr    <= 1'b1;
        byte_cnt <= byte_cnt + 17'd1;
      end else if (wr_in_load) begin
        bad      <= 1'b1;
      end
    end
  end

  // Status outputs registered from the next state so they track state exactly.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      core_reset_n <= 1'b0;
      rom_ready    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      core_reset_n <= (state_n == S_RUN);
      rom_ready    <= (state_n == S_RUN);
      load_error   <= (state_n == S_ERROR);
    end
  end

endmodule
